amm_ram_slave: RTL
==================

// Module: amm_ram_slave
// PURPOSE
//  Synthesizable Avalon-MM slave: byte-enabled single-port RAM with burst support.
//  Responder end of the Avalon-MM link; sits behind amm_cdc (slave side) or directly on a master port.
//  Word-addressed; single outstanding command.
// PARAMETERS
//  ADDR_W    8   word address width; depth = 2**ADDR_W words
//  DATA_W    64  data width; multiple of 8
//  BURST_W   2   burstcount width; max burst = 2**(BURST_W-1) beats
//  RD_LAT    1   read latency, 1 (RAM only) or 2 (extra output register)
// PORTS
//  clk_i               in   1         clock
//  rst_i               in   1         synchronous, active-high reset
//  amm_address_i       in   ADDR_W    word address
//  amm_read_i          in   1         read request
//  amm_write_i         in   1         write request / write beat
//  amm_writedata_i     in   DATA_W    write data
//  amm_byteenable_i    in   DATA_W/8  byte lanes to write
//  amm_burstcount_i    in   BURST_W   beats; sampled on the first beat only
//  amm_waitrequest_o   out  1         command/beat not accepted
//  amm_readdata_o      out  DATA_W    read data
//  amm_readdatavalid_o out  1         readdata valid
//  err_o               out  1         sticky protocol-violation flag
// BEHAVIOUR
//  Reset: waitrequest=1, readdatavalid=0, readdata=0, err_o=0, FSM=IDLE, burst counters=0.
//   RAM contents are not cleared. Waitrequest drops on the first cycle after rst_i falls.
//  Beat accepted = (read|write) & !waitrequest. burstcount 0 is treated as 1.
//  FSM IDLE:
//   - write accepted: commit beat 0 to RAM at address with byteenable.
//     If burst>1: latch addr+1 and remaining=burst-1, go WR_BURST.
//   - read accepted: latch addr and remaining=burst, assert waitrequest next cycle, go RD_BURST.
//   - read & write same cycle: write wins, read dropped, err_o<=1.
//  FSM WR_BURST (waitrequest=0):
//   - Each write beat is committed at the latched addr; addr++, remaining--.
//   - Address on beats after the first is ignored. Idle cycles (write=0) are allowed.
//   - Last beat -> IDLE. Read asserted -> ignored, err_o<=1.
//  FSM RD_BURST (waitrequest=1):
//   - Issue one RAM read per cycle at addr; addr++, remaining--.
//   - After the last issue -> IDLE (waitrequest=0 that same next cycle).
//  Latency: a RAM read issued in cycle N gives readdatavalid=1 with data in cycle N+RD_LAT.
//   Burst beats come back on consecutive cycles. No backpressure on readdata.
//  Back-to-back: a new read is accepted in IDLE while earlier data is still in flight.
//   Return order is preserved.
//  Address wrap: 2**ADDR_W-1 increments to 0.
//  Byteenable 0 on a write beat: beat consumed, RAM unchanged.
//  Read-during-write to the same word never occurs (single port, FSM serialises).
//  Reset mid-burst: FSM -> IDLE, in-flight readdatavalid pipeline flushed to 0.
//   Partially written bursts keep the beats already committed.
//  err_o clears only on reset.
// STRUCTURE
//  amm_pkg:
//   - typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} amm_slv_state_t
//   - function burst_len(bc) mapping 0->1
//  Sub-module amm_ram_sp:
//   - single-port RAM, per-byte write enable, 1-cycle registered read, ADDR_W/DATA_W params
//  Top: FSM, address/remaining counters, RD_LAT valid/data shift pipeline.
// TESTING
//  1 single write then read:
//    wr addr 0x10 data 0x0123456789ABCDEF be 0xFF; rd 0x10
//    -> readdata 0x0123456789ABCDEF, valid RD_LAT cycles after the RAM issue.
//  2 partial write:
//    wr 0x20 all 0xFF.., then wr 0x20 data 0 be 0x0F; rd 0x20 -> 0xFFFFFFFF00000000.
//  3 burst wrap:
//    burst-2 write at 0xFF with A,B; burst-2 read at 0xFF
//    -> A then B on consecutive valid cycles. Read of 0x00 returns B.
//  4 back-to-back reads:
//    rd 0x01 burst 1 then immediately rd 0x02 burst 2
//    -> 3 valid beats in order, no gaps beyond one-cycle re-accept.
//  5 collision: read & write together in IDLE
//    -> write committed, no readdatavalid, err_o=1 until reset.
//  6 reset mid read burst: rst_i pulsed 1 cycle after burst-2 read accepted
//    -> readdatavalid 0 throughout, waitrequest high in reset, FSM IDLE after.

Source files
------------

// File: rtl/amm_pkg.sv
// Shared types and helpers for the Avalon-MM RAM slave.
package amm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } amm_slv_state_t;

    // A burstcount of zero is treated as a single-beat transfer.
    function automatic int unsigned burst_len(input int unsigned bc);
        return (bc == 0) ? 1 : bc;
    endfunction

endpackage

// File: rtl/amm_ram_slave_if.sv
// Avalon-MM command/response bundle between a master and the RAM slave.
interface amm_ram_slave_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 2
);
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [BURST_W-1:0]  burstcount;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/amm_ram_sp.sv
// Single-port RAM with per-byte write enables and a registered read port.
// Only the read register is reset; the array itself keeps its contents.
module amm_ram_sp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic                re_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   rdata_o
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane writes into the array.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // Registered read, one cycle after the issue.
    always_ff @(posedge clk_i) begin
        if (rst_i)     rdata_q <= '0;
        else if (re_i) rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/amm_ram_slave.sv
// Avalon-MM burst-capable RAM slave. One command outstanding at a time;
// reads are issued one word per cycle while waitrequest is held high.
//
// state    | meaning
// IDLE     | accepting a new read or write command
// WR_BURST | collecting the remaining write beats of a burst
// RD_BURST | issuing RAM reads for a read burst, waitrequest high
module amm_ram_slave
    import amm_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int BURST_W = 2,
    parameter int RD_LAT  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    amm_ram_slave_if.slave   amm,
    output logic             err_o
);
    amm_slv_state_t      state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BURST_W-1:0]  rem_q, rem_d;
    logic                err_q, err_d;
    logic                wait_q;

    logic                accept_wr, accept_rd;
    logic [BURST_W-1:0]  bc_len;
    logic                ram_we, ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_rdata;

    assign accept_wr = amm.write & ~wait_q;
    assign accept_rd = amm.read & ~wait_q;
    assign bc_len    = BURST_W'(burst_len(32'(amm.burstcount)));

    // State, counters and the registered waitrequest.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            wait_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            wait_q  <= (state_d == RD_BURST);
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_wr) begin
                    if (bc_len != BURST_W'(1)) state_d = WR_BURST;
                end else if (accept_rd) begin
                    state_d = RD_BURST;
                end
            end
            WR_BURST: if (accept_wr && rem_q == BURST_W'(1)) state_d = IDLE;
            RD_BURST: if (rem_q == BURST_W'(1)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // RAM strobes, counter updates and protocol-error detection.
    always_comb begin
        addr_d   = addr_q;
        rem_d    = rem_q;
        err_d    = err_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = addr_q;
        case (state_q)
            IDLE: begin
                ram_addr = amm.address;
                if (accept_wr) begin
                    ram_we = 1'b1;
                    addr_d = amm.address + 1'b1;
                    rem_d  = bc_len - 1'b1;
                    if (amm.read) err_d = 1'b1;
                end else if (accept_rd) begin
                    addr_d = amm.address;
                    rem_d  = bc_len;
                end
            end
            WR_BURST: begin
                if (accept_wr) begin
                    ram_we = 1'b1;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                end
                if (amm.read) err_d = 1'b1;
            end
            RD_BURST: begin
                ram_re = 1'b1;
                addr_d = addr_q + 1'b1;
                rem_d  = rem_q - 1'b1;
            end
            default: ;
        endcase
    end

    amm_ram_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (amm.writedata),
        .be_i    (amm.byteenable),
        .rdata_o (ram_rdata)
    );

    generate
        if (RD_LAT == 1) begin : g_lat1
            logic vld_q;
            // Valid tracks the RAM read register directly.
            always_ff @(posedge clk_i) begin
                if (rst_i) vld_q <= 1'b0;
                else       vld_q <= ram_re;
            end
            assign amm.readdatavalid = vld_q;
            assign amm.readdata      = ram_rdata;
        end else begin : g_lat2
            logic              vld1_q, vld2_q;
            logic [DATA_W-1:0] data_q;
            // Extra output stage on both data and valid.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    vld1_q <= 1'b0;
                    vld2_q <= 1'b0;
                    data_q <= '0;
                end else begin
                    vld1_q <= ram_re;
                    vld2_q <= vld1_q;
                    data_q <= ram_rdata;
                end
            end
            assign amm.readdatavalid = vld2_q;
            assign amm.readdata      = data_q;
        end
    endgenerate

    assign amm.waitrequest = wait_q;
    assign err_o           = err_q;
endmodule
